cone_see_sweep_checker: RTL and testbench
=========================================

// Module: cone_see_sweep_checker
// PURPOSE
// Stimulus-and-compare stage wrapped around a combinational logic cone under SEE analysis.
// Drives every input combination exhaustively into two copies of the cone:
//   - a golden copy
//   - a fault-injected copy
// After each vector it waits a settle window, samples both cone outputs and compares them.
// It counts mismatches and captures the first failing vector, for readout by the campaign controller.
// PARAMETERS
// N_IN    9   number of cone inputs; vec_o bit k drives cone input i_k_
// SETTLE  2   cycles between applying a vector and sampling it; legal range 1..15
// CNT_W   16  width of the mismatch counter
// PORTS
// clk            in   1      single clock; all state updates on rising edge
// rst            in   1      asynchronous reset, active-high
// start          in   1      one-cycle request to begin a sweep; honoured only in IDLE or DONE
// abort          in   1      stop the current sweep; honoured only while busy
// gold_i         in   1      output o_0_ of the golden cone
// dut_i          in   1      output o_0_ of the fault-injected cone
// vec_o          out  N_IN   registered input vector, wired to both cones
// busy           out  1      high in SETTLE or SAMPLE
// done           out  1      high in DONE; held until the next start or rst
// err_cnt        out  CNT_W  mismatch count; saturates at all-ones
// first_err_vec  out  N_IN   vec_o value at the first mismatch of this sweep
// first_err_vld  out  1      first_err_vec holds valid data
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; every output and internal counter = 0.
// - States: IDLE, SETTLE, SAMPLE, DONE. Next state is registered; all outputs are registered.
// - IDLE/DONE on start: vec_o<=0, err_cnt<=0, first_err_vec<=0, first_err_vld<=0, done<=0,
//   settle counter<=SETTLE-1, go to SETTLE.
// - SETTLE: decrement settle counter; when it is 0, go to SAMPLE.
//   Time spent in SETTLE per vector is exactly SETTLE cycles.
// - SAMPLE: the compare uses gold_i and dut_i as sampled on this clock edge.
//   - Mismatch (gold_i!=dut_i): err_cnt<=err_cnt+1, unless it is all-ones (then it holds).
//   - Mismatch with first_err_vld=0: first_err_vec<=vec_o and first_err_vld<=1.
//   - vec_o == all-ones: go to DONE and set done<=1; vec_o holds its last value.
//   - Otherwise: vec_o<=vec_o+1, reload settle counter with SETTLE-1, go to SETTLE.
// - Per-vector period is SETTLE+1 cycles.
// - done rises 2^N_IN*(SETTLE+1) cycles after the edge that accepts start.
//   Defaults: 512*3 = 1536 cycles.
// - start while busy: ignored, no effect on any state.
// - abort while busy: go to IDLE on the next edge with busy=0 and done=0.
//   vec_o, err_cnt, first_err_* hold their values for post-mortem.
// - abort in IDLE/DONE: ignored.
// - start and abort in the same cycle: in IDLE/DONE start wins; while busy abort wins.
// - first_err_vld, once set, stays set until the next start or rst.
//   Later mismatches never overwrite first_err_vec.
// - X on gold_i or dut_i is treated as a compare input as-is; this block does no X filtering.
// - vec_o increments as unsigned; no wrap occurs inside a sweep, since the terminal vector ends it.
// TESTING
// T1 dut_i tied to gold_i, defaults: start
//    -> busy for 1536 cycles, done=1, err_cnt=0, first_err_vld=0, vec_o=9'h1FF.
// T2 dut_i = gold_i inverted only when vec_o==9'h1A5
//    -> err_cnt=1, first_err_vec=9'h1A5, first_err_vld=1.
// T3 gold_i=0, dut_i=1 constant, CNT_W=8
//    -> err_cnt saturates at 8'hFF; first_err_vec=0.
// T4 assert abort 100 cycles after start, then pulse start twice while busy in a second run
//    -> after abort: IDLE next cycle, busy=0, done=0, counters held.
//    -> during second run: extra starts ignored, done still at 1536 cycles.
// T5 assert rst mid-sweep (vec_o=9'h040), release, then start
//    -> all outputs 0 immediately on rst; the fresh sweep restarts from vec_o=0.
// T6 SETTLE=1, mismatch injected only while vec_o==0 during the settle window
//    (not at the sample edge) -> err_cnt=0.

Source files
------------

// File: rtl/cone_see_sweep_checker.sv
// Exhaustive stimulus/compare stage for a golden and a fault-injected logic cone.
// Sweeps every input vector, samples both cone outputs after a settle window, and logs mismatches.
//
// state  | meaning
// IDLE   | waiting for start; results of an aborted sweep are held
// SETTLE | vector applied, waiting SETTLE cycles for the cones to settle
// SAMPLE | compare gold_i/dut_i, then advance or finish
// DONE   | sweep complete; results held until next start
module cone_see_sweep_checker #(
  parameter int N_IN   = 9,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             gold_i,
  input  logic             dut_i,
  output logic [N_IN-1:0]  vec_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_vld
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [N_IN-1:0]  fev_q, fev_d;
  logic             fvld_q, fvld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mismatch;

  assign mismatch = (gold_i != dut_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      vec_q    <= '0;
      err_q    <= '0;
      fev_q    <= '0;
      fvld_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      fev_q    <= fev_d;
      fvld_q   <= fvld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Abort outranks everything while busy; start is only looked at when not busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (abort)               state_d = S_IDLE;
        else if (settle_q == '0) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)       state_d = S_IDLE;
        else if (&vec_q) state_d = S_DONE;
        else             state_d = S_SETTLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    settle_d = settle_q;
    vec_d    = vec_q;
    err_d    = err_q;
    fev_d    = fev_q;
    fvld_d   = fvld_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          settle_d = SETTLE_LD;
          vec_d    = '0;
          err_d    = '0;
          fev_d    = '0;
          fvld_d   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (!abort && settle_q != '0) settle_d = settle_q - 4'd1;
      end
      S_SAMPLE: begin
        if (!abort) begin
          if (mismatch) begin
            if (!(&err_q)) err_d = err_q + 1'b1;
            if (!fvld_q) begin
              fev_d  = vec_q;
              fvld_d = 1'b1;
            end
          end
          // The terminal vector ends the sweep, so vec_o never wraps.
          if (!(&vec_q)) begin
            vec_d    = vec_q + 1'b1;
            settle_d = SETTLE_LD;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  assign vec_o         = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_cnt       = err_q;
  assign first_err_vec = fev_q;
  assign first_err_vld = fvld_q;

endmodule

// File: tb/tb_cone_see_sweep_checker.sv
// Bench for cone_see_sweep_checker: two instances (default, and SETTLE=1/CNT_W=8),
// behavioural cones driven from vec_o, and an expected-result queue checked at sweep end.
module tb_cone_see_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, abort_a, start_b, abort_b;
  logic        gold_a, dut_a_i, gold_b, dut_b_i;
  logic [8:0]  vec_a, vec_b, fev_a, fev_b;
  logic [15:0] err_a;
  logic [7:0]  err_b;
  logic        busy_a, busy_b, done_a, done_b, vld_a, vld_b;

  int   mode_a, mode_b;
  logic glitch;

  // mode 0: identical cones, 1: fault at 9'h1A5, 2: gold=0/dut=1, 3: fault while glitch is high
  function automatic logic gold_fn(logic [8:0] v, int mode);
    return (mode == 2) ? 1'b0 : ^v;
  endfunction

  function automatic logic fault_fn(logic [8:0] v, int mode, logic g);
    case (mode)
      1:       return (^v) ^ (v == 9'h1A5);
      2:       return 1'b1;
      3:       return (^v) ^ g;
      default: return ^v;
    endcase
  endfunction

  assign gold_a  = gold_fn(vec_a, mode_a);
  assign dut_a_i = fault_fn(vec_a, mode_a, glitch);
  assign gold_b  = gold_fn(vec_b, mode_b);
  assign dut_b_i = fault_fn(vec_b, mode_b, glitch);

  cone_see_sweep_checker u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .gold_i(gold_a), .dut_i(dut_a_i), .vec_o(vec_a), .busy(busy_a), .done(done_a),
    .err_cnt(err_a), .first_err_vec(fev_a), .first_err_vld(vld_a)
  );

  cone_see_sweep_checker #(.N_IN(9), .SETTLE(1), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .gold_i(gold_b), .dut_i(dut_b_i), .vec_o(vec_b), .busy(busy_b), .done(done_b),
    .err_cnt(err_b), .first_err_vec(fev_b), .first_err_vld(vld_b)
  );

  int sel;
  logic [8:0]  vec_m, fev_m;
  logic [15:0] err_m;
  logic        busy_m, done_m, vld_m;
  assign vec_m  = (sel == 1) ? vec_b : vec_a;
  assign fev_m  = (sel == 1) ? fev_b : fev_a;
  assign err_m  = (sel == 1) ? {8'h00, err_b} : err_a;
  assign busy_m = (sel == 1) ? busy_b : busy_a;
  assign done_m = (sel == 1) ? done_b : done_a;
  assign vld_m  = (sel == 1) ? vld_b : vld_a;

  typedef struct {
    string name;
    int    sel;
    int    mode;
    int    cycles;
    int    err;
    int    fev;
    int    vld;
    int    vec;
  } sweep_t;

  sweep_t tbl[5];
  sweep_t sb_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic set_start(int s, logic v);
    if (s == 1) start_b = v; else start_a = v;
  endtask

  task automatic set_abort(int s, logic v);
    if (s == 1) abort_b = v; else abort_a = v;
  endtask

  task automatic do_start(int s, bit with_abort);
    @(negedge clk);
    set_start(s, 1'b1);
    if (with_abort) set_abort(s, 1'b1);
    @(posedge clk);
    #1;
    set_start(s, 1'b0);
    set_abort(s, 1'b0);
  endtask

  task automatic run_sweep(sweep_t e, bit with_abort, bit extra_starts);
    int  cycles;
    bit  busy_ok;
    sweep_t x;
    sel = e.sel;
    if (e.sel == 1) mode_b = e.mode; else mode_a = e.mode;
    do_start(e.sel, with_abort);
    sb_q.push_back(e);
    if (e.mode == 3) glitch = 1'b1;
    chk({e.name, "_vec_at_start"}, int'(vec_m), 0);
    chk({e.name, "_busy_at_start"}, int'(busy_m), 1);
    cycles  = 0;
    busy_ok = 1'b1;
    while (!done_m && cycles < 4000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) glitch = 1'b0;
      if (extra_starts && (cycles == 10 || cycles == 500)) set_start(e.sel, 1'b1);
      if (extra_starts && (cycles == 11 || cycles == 501)) set_start(e.sel, 1'b0);
      if (!done_m && !busy_m) busy_ok = 1'b0;
    end
    x = sb_q.pop_front();
    chk({x.name, "_done_cycles"}, cycles, x.cycles);
    chk({x.name, "_busy_window"}, int'(busy_ok), 1);
    chk({x.name, "_busy_at_done"}, int'(busy_m), 0);
    chk({x.name, "_err_cnt"}, int'(err_m), x.err);
    chk({x.name, "_first_err_vec"}, int'(fev_m), x.fev);
    chk({x.name, "_first_err_vld"}, int'(vld_m), x.vld);
    chk({x.name, "_vec_final"}, int'(vec_m), x.vec);
  endtask

  initial begin
    tbl[0] = '{"t1_clean",   0, 0, 1536, 0,   9'h000, 0, 9'h1FF};
    tbl[1] = '{"t2_single",  0, 1, 1536, 1,   9'h1A5, 1, 9'h1FF};
    tbl[2] = '{"t3_sat",     1, 2, 1024, 255, 9'h000, 1, 9'h1FF};
    tbl[3] = '{"b_single",   1, 1, 1024, 1,   9'h1A5, 1, 9'h1FF};
    tbl[4] = '{"t6_glitch",  1, 3, 1024, 0,   9'h000, 0, 9'h1FF};

    start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
    mode_a = 0; mode_b = 0; glitch = 0; sel = 0;
    rst = 1'b1;
    #2;
    chk("rst_vec", int'(vec_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_vld", int'(vld_a), 0);
    chk("rst_b_busy", int'(busy_b), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_sweep(tbl[i], 1'b0, 1'b0);

    // abort after 100 cycles with a constant mismatch: 33 vectors sampled so far
    sel = 0;
    mode_a = 2;
    do_start(0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
    end
    abort_a = 1'b1;
    @(posedge clk);
    #1;
    abort_a = 1'b0;
    chk("t4_abort_busy", int'(busy_a), 0);
    chk("t4_abort_done", int'(done_a), 0);
    chk("t4_abort_vec", int'(vec_a), 33);
    chk("t4_abort_err", int'(err_a), 33);
    chk("t4_abort_fev", int'(fev_a), 0);
    chk("t4_abort_vld", int'(vld_a), 1);
    @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_idle_abort_busy", int'(busy_a), 0);
    chk("t4_idle_abort_err", int'(err_a), 33);
    chk("t4_idle_abort_vec", int'(vec_a), 33);
    begin
      sweep_t e;
      e = '{"t4_rerun", 0, 0, 1536, 0, 9'h000, 0, 9'h1FF};
      run_sweep(e, 1'b1, 1'b1);
    end

    // reset mid-sweep at vector 0x040
    sel = 0;
    mode_a = 0;
    do_start(0, 1'b0);
    for (int i = 0; i < 192; i++) begin
      @(posedge clk);
      #1;
    end
    chk("t5_pre_vec", int'(vec_a), 9'h040);
    rst = 1'b1;
    #1;
    chk("t5_rst_vec", int'(vec_a), 0);
    chk("t5_rst_busy", int'(busy_a), 0);
    chk("t5_rst_err", int'(err_a), 0);
    chk("t5_rst_done", int'(done_a), 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      sweep_t e;
      e = '{"t5_restart", 0, 0, 1536, 0, 9'h000, 0, 9'h1FF};
      run_sweep(e, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
